// File: rtl/dac_spi_pkg.sv
// Shared types and helpers for the multi-channel DAC SPI serializer.
package dac_spi_pkg;

  localparam int unsigned MaxCh  = 32;
  localparam int unsigned MaxChW = 5;

  typedef enum logic [2:0] {
    StIdle, StLoad, StSetup, StShift, StHold, StGap, StDone
  } state_e;

  typedef struct packed {
    logic              none;
    logic [MaxChW-1:0] idx;
  } ch_sel_t;

  function automatic int frame_pad(int frame_w, int cmd_w, int data_w);
    return frame_w - cmd_w - data_w;
  endfunction

  // Lowest set bit strictly above cur; pass cur = -1 to search from bit 0.
  function automatic ch_sel_t next_ch(logic [MaxCh-1:0] mask, int cur);
    ch_sel_t sel;
    sel.none = 1'b1;
    sel.idx  = '0;
    for (int i = MaxCh - 1; i >= 0; i--) begin
      if (mask[i] && (i > cur)) begin
        sel.none = 1'b0;
        sel.idx  = MaxChW'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/dac_spi_multi_if.sv
// Request/status and SPI pin bundle of the DAC serializer.
interface dac_spi_multi_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned CMD_W    = 4,
  parameter int unsigned DATA_W   = 8
);
  localparam int unsigned CurW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                       start;
  logic [CHANNELS-1:0]        ch_mask;
  logic [CHANNELS*CMD_W-1:0]  cmd;
  logic [CHANNELS*DATA_W-1:0] data;
  logic                       dac_sclk;
  logic [CHANNELS-1:0]        dac_cs;
  logic                       dac_sdo;
  logic                       busy;
  logic                       done;
  logic [CurW-1:0]            cur_ch;

  modport master (
    output start, ch_mask, cmd, data,
    input  dac_sclk, dac_cs, dac_sdo, busy, done, cur_ch
  );

  modport slave (
    input  start, ch_mask, cmd, data,
    output dac_sclk, dac_cs, dac_sdo, busy, done, cur_ch
  );
endinterface

// File: rtl/dac_sclk_div.sv
// SCLK generator: toggles every CLK_DIV enabled cycles, starting low, rising first.
module dac_sclk_div #(
  parameter int unsigned CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);
  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            tick;

  assign tick = en_i && (cnt_q == CntW'(CLK_DIV - 1));

  always_comb begin
    cnt_d  = cnt_q + CntW'(1);
    sclk_d = sclk_q;
    if (tick) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || !en_i) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign rise_stb_o = tick & ~sclk_q;
  assign fall_stb_o = tick & sclk_q;
endmodule

// File: rtl/dac_spi_multi.sv
// Sends one command+data+pad SPI frame to each enabled DAC channel per start request.
module dac_spi_multi
  import dac_spi_pkg::*;
#(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned CMD_W      = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FRAME_W    = 16,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned GAP_CLKS   = 2,
  parameter bit          CS_ACT_LOW = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  dac_spi_multi_if.slave bus
);
  localparam int          Pad   = frame_pad(FRAME_W, CMD_W, DATA_W);
  localparam int unsigned CurW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BitW  = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam int unsigned CntW  = $clog2(CLK_DIV + GAP_CLKS + 1);
  localparam int unsigned WordW = CMD_W + DATA_W;

  if (Pad < 0) begin : g_bad_pad
    $error("FRAME_W smaller than CMD_W + DATA_W");
  end
  if (CHANNELS < 1 || CHANNELS > MaxCh) begin : g_bad_ch
    $error("CHANNELS out of range");
  end
  if (CLK_DIV < 1 || GAP_CLKS < 1) begin : g_bad_timing
    $error("CLK_DIV and GAP_CLKS must be at least 1");
  end

  state_e                     state_q;
  logic [CHANNELS-1:0]        mask_q;
  logic [CHANNELS*CMD_W-1:0]  cmd_q;
  logic [CHANNELS*DATA_W-1:0] data_q;
  logic [CurW-1:0]            cur_ch_q;
  logic [CHANNELS-1:0]        cs_q;
  logic [FRAME_W-1:0]         sreg_q;
  logic [BitW-1:0]            bit_q;
  logic [CntW-1:0]            cnt_q;
  logic                       busy_q, done_q;

  logic                       sclk, rise_stb, fall_stb;
  ch_sel_t                    nxt;
  logic [CurW-1:0]            sel_idx;
  logic [WordW-1:0]           word;
  logic [FRAME_W-1:0]         frame;

  dac_sclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_div (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .en_i      (state_q == StShift),
    .sclk_o    (sclk),
    .rise_stb_o(rise_stb),
    .fall_stb_o(fall_stb)
  );

  // In LOAD search from bit 0; in GAP continue above the channel just sent.
  always_comb begin
    nxt     = next_ch(MaxCh'(mask_q), (state_q == StLoad) ? -1 : int'(cur_ch_q));
    sel_idx = CurW'(nxt.idx);
    word    = {cmd_q[sel_idx*CMD_W +: CMD_W], data_q[sel_idx*DATA_W +: DATA_W]};
    frame   = FRAME_W'(word) << Pad;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      mask_q   <= '0;
      cmd_q    <= '0;
      data_q   <= '0;
      cur_ch_q <= '0;
      cs_q     <= '0;
      sreg_q   <= '0;
      bit_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            mask_q  <= bus.ch_mask;
            cmd_q   <= bus.cmd;
            data_q  <= bus.data;
            busy_q  <= 1'b1;
            state_q <= StLoad;
          end
        end
        StLoad, StGap: begin
          if (state_q == StLoad || cnt_q == CntW'(GAP_CLKS - 1)) begin
            cnt_q <= '0;
            if (nxt.none) begin
              state_q  <= StDone;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              cur_ch_q <= '0;
            end else begin
              state_q  <= StSetup;
              cur_ch_q <= sel_idx;
              cs_q     <= CHANNELS'(1) << nxt.idx;
              sreg_q   <= frame;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StSetup: begin
          if (cnt_q == CntW'(CLK_DIV - 1)) begin
            state_q <= StShift;
            bit_q   <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StShift: begin
          if (fall_stb) begin
            sreg_q <= sreg_q << 1;
            bit_q  <= bit_q + BitW'(1);
            if (bit_q == BitW'(FRAME_W - 1)) begin
              state_q <= StHold;
              cnt_q   <= '0;
            end
          end
        end
        StHold: begin
          if (cnt_q == CntW'(CLK_DIV - 1)) begin
            cs_q    <= '0;
            state_q <= StGap;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // rise_stb is implied by the divider phase; only the falling strobe shifts data.
  logic unused_rise;
  assign unused_rise = rise_stb;

  assign bus.dac_sclk = sclk;
  assign bus.dac_cs   = CS_ACT_LOW ? ~cs_q : cs_q;
  assign bus.dac_sdo  = sreg_q[FRAME_W-1];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.cur_ch   = cur_ch_q;
endmodule

// File: tb/tb_dac_spi_multi.sv
// Directed bench: default 2-channel DUT (a) and a 4-channel, CLK_DIV=3, active-low CS DUT (b).
module tb_dac_spi_multi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_spi_multi_if #(.CHANNELS(2), .CMD_W(4), .DATA_W(8))  ifa ();
  dac_spi_multi_if #(.CHANNELS(4), .CMD_W(4), .DATA_W(12)) ifb ();

  dac_spi_multi u_dut_a (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifa.slave)
  );

  dac_spi_multi #(
    .CHANNELS(4), .CMD_W(4), .DATA_W(12), .FRAME_W(16), .CLK_DIV(3), .GAP_CLKS(2),
    .CS_ACT_LOW(1'b1)
  ) u_dut_b (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (ifb.slave)
  );

  int vec = 0;
  int err = 0;

  logic [15:0] cap_w[$];
  logic [3:0]  cap_cs[$];
  int          cap_cur[$];
  int          done_cnt, done_cyc, busy_cyc, act_cyc, viol, halfbad;

  task automatic go(input bit sel);
    @(negedge clk);
    if (sel) ifb.start = 1'b1;
    else     ifa.start = 1'b1;
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the edge that accepted start.
  task automatic mon(input bit sel, input int half, input int budget);
    logic       sclk, prev, sdo;
    logic [3:0] cs, fcs;
    logic [15:0] acc;
    int nb, hi, cur;
    cap_w.delete(); cap_cs.delete(); cap_cur.delete();
    done_cnt = 0; done_cyc = -1; busy_cyc = 0; act_cyc = 0; viol = 0; halfbad = 0;
    prev = 1'b0; nb = 0; hi = 0; acc = '0; fcs = '0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      sclk = sel ? ifb.dac_sclk : ifa.dac_sclk;
      sdo  = sel ? ifb.dac_sdo : ifa.dac_sdo;
      cs   = sel ? ~ifb.dac_cs : {2'b00, ifa.dac_cs};
      cur  = sel ? int'(ifb.cur_ch) : int'(ifa.cur_ch);
      if (sel ? ifb.busy : ifa.busy) busy_cyc++;
      if (cs != 4'b0) act_cyc++;
      if ($countones(cs) > 1) viol++;
      if (sclk !== prev && cs == 4'b0) viol++;
      if (sclk) hi++;
      else if (hi > 0) begin
        if (hi != half) halfbad++;
        hi = 0;
      end
      if (!prev && sclk) begin
        acc = {acc[14:0], sdo};
        if (nb == 0) begin
          fcs = cs;
          cap_cur.push_back(cur);
        end else if (cs != fcs) viol++;
        nb++;
        if (nb == 16) begin
          cap_w.push_back(acc);
          cap_cs.push_back(fcs);
          nb = 0;
        end
      end
      prev = sclk;
      if (sel ? ifb.done : ifa.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vec++; if (ifa.dac_sclk !== 1'b0) begin err++; $display("FAIL reset_sclk got %b want 0", ifa.dac_sclk); end
    vec++; if (ifa.dac_cs !== 2'b00) begin err++; $display("FAIL reset_cs_a got %b want 00", ifa.dac_cs); end
    vec++; if (ifb.dac_cs !== 4'hF) begin err++; $display("FAIL reset_cs_b got %b want 1111", ifb.dac_cs); end
    vec++; if ({ifa.dac_sdo, ifa.busy, ifa.done} !== 3'b000) begin
      err++; $display("FAIL reset_sdo_busy_done got %b want 000", {ifa.dac_sdo, ifa.busy, ifa.done});
    end
    vec++; if (ifa.cur_ch !== 1'b0) begin err++; $display("FAIL reset_cur_ch got %0d want 0", ifa.cur_ch); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_two_frames(input string tag);
    vec++; if (cap_w.size() !== 2) begin err++; $display("FAIL %s_nframes got %0d want 2", tag, cap_w.size()); end
    vec++; if (cap_w[0] !== 16'h7A50) begin err++; $display("FAIL %s_frame0 got %h want 7a50", tag, cap_w[0]); end
    vec++; if (cap_w[1] !== 16'hF3C0) begin err++; $display("FAIL %s_frame1 got %h want f3c0", tag, cap_w[1]); end
    vec++; if (done_cyc !== 74) begin err++; $display("FAIL %s_done_cycle got %0d want 74", tag, done_cyc); end
    vec++; if (done_cnt !== 1) begin err++; $display("FAIL %s_done_count got %0d want 1", tag, done_cnt); end
  endtask

  task automatic test_two_ch;
    ifa.ch_mask = 2'b11; ifa.cmd = {4'b1111, 4'b0111}; ifa.data = {8'h3C, 8'hA5};
    go(1'b0);
    mon(1'b0, 1, 200);
    check_two_frames("two_ch");
    vec++; if (cap_cs[0] !== 4'b0001 || cap_cs[1] !== 4'b0010) begin
      err++; $display("FAIL two_ch_cs got %b,%b want 0001,0010", cap_cs[0], cap_cs[1]);
    end
    vec++; if (cap_cur[0] !== 0 || cap_cur[1] !== 1) begin
      err++; $display("FAIL two_ch_cur got %0d,%0d want 0,1", cap_cur[0], cap_cur[1]);
    end
    vec++; if (busy_cyc !== 73) begin err++; $display("FAIL two_ch_busy got %0d want 73", busy_cyc); end
    vec++; if (act_cyc !== 68) begin err++; $display("FAIL two_ch_cs_cycles got %0d want 68", act_cyc); end
    vec++; if (viol !== 0 || halfbad !== 0) begin
      err++; $display("FAIL two_ch_protocol got viol=%0d halfbad=%0d want 0,0", viol, halfbad);
    end
  endtask

  task automatic test_single;
    ifa.ch_mask = 2'b10;
    go(1'b0);
    mon(1'b0, 1, 200);
    vec++; if (cap_w.size() !== 1) begin err++; $display("FAIL single_nframes got %0d want 1", cap_w.size()); end
    vec++; if (cap_w[0] !== 16'hF3C0) begin err++; $display("FAIL single_frame got %h want f3c0", cap_w[0]); end
    vec++; if (cap_cs[0] !== 4'b0010) begin err++; $display("FAIL single_cs got %b want 0010", cap_cs[0]); end
    vec++; if (cap_cur[0] !== 1) begin err++; $display("FAIL single_cur got %0d want 1", cap_cur[0]); end
    vec++; if (done_cyc !== 38) begin err++; $display("FAIL single_done_cycle got %0d want 38", done_cyc); end
    vec++; if (busy_cyc !== 37) begin err++; $display("FAIL single_busy got %0d want 37", busy_cyc); end
  endtask

  task automatic test_empty;
    ifa.ch_mask = 2'b00;
    go(1'b0);
    mon(1'b0, 1, 50);
    vec++; if (done_cyc !== 2) begin err++; $display("FAIL empty_done_cycle got %0d want 2", done_cyc); end
    vec++; if (busy_cyc !== 1) begin err++; $display("FAIL empty_busy got %0d want 1", busy_cyc); end
    vec++; if (act_cyc !== 0 || cap_cur.size() !== 0) begin
      err++; $display("FAIL empty_activity got cs_cycles=%0d rises=%0d want 0,0", act_cyc, cap_cur.size());
    end
  endtask

  task automatic test_wide;
    ifb.ch_mask = 4'b0101;
    ifb.cmd  = {4'h0, 4'h6, 4'h0, 4'h9};
    ifb.data = {12'h000, 12'h123, 12'h000, 12'hABC};
    go(1'b1);
    mon(1'b1, 3, 400);
    vec++; if (cap_w.size() !== 2) begin err++; $display("FAIL wide_nframes got %0d want 2", cap_w.size()); end
    vec++; if (cap_w[0] !== 16'h9ABC) begin err++; $display("FAIL wide_frame0 got %h want 9abc", cap_w[0]); end
    vec++; if (cap_w[1] !== 16'h6123) begin err++; $display("FAIL wide_frame1 got %h want 6123", cap_w[1]); end
    vec++; if (cap_cs[0] !== 4'b0001 || cap_cs[1] !== 4'b0100) begin
      err++; $display("FAIL wide_cs got %b,%b want 0001,0100", cap_cs[0], cap_cs[1]);
    end
    vec++; if (cap_cur[0] !== 0 || cap_cur[1] !== 2) begin
      err++; $display("FAIL wide_cur got %0d,%0d want 0,2", cap_cur[0], cap_cur[1]);
    end
    vec++; if (done_cyc !== 210) begin err++; $display("FAIL wide_done_cycle got %0d want 210", done_cyc); end
    vec++; if (act_cyc !== 204) begin err++; $display("FAIL wide_cs_cycles got %0d want 204", act_cyc); end
    vec++; if (viol !== 0 || halfbad !== 0) begin
      err++; $display("FAIL wide_protocol got viol=%0d halfbad=%0d want 0,0", viol, halfbad);
    end
  endtask

  task automatic test_snapshot;
    ifa.ch_mask = 2'b11; ifa.cmd = {4'b1111, 4'b0111}; ifa.data = {8'h3C, 8'hA5};
    go(1'b0);
    fork
      mon(1'b0, 1, 200);
      begin
        repeat (10) @(negedge clk);
        ifa.start = 1'b1; ifa.data = 16'hFFFF; ifa.cmd = 8'h00; ifa.ch_mask = 2'b01;
        @(negedge clk);
        ifa.start = 1'b0;
      end
    join
    check_two_frames("snapshot");
  endtask

  task automatic test_reset_mid;
    ifa.ch_mask = 2'b11; ifa.cmd = {4'b1111, 4'b0111}; ifa.data = {8'h3C, 8'hA5};
    go(1'b0);
    repeat (16) @(negedge clk);
    vec++; if (ifa.dac_sclk !== 1'b1 || ifa.dac_cs !== 2'b01) begin
      err++; $display("FAIL mid_bit7 got sclk=%b cs=%b want 1,01", ifa.dac_sclk, ifa.dac_cs);
    end
    rst_n = 1'b0;
    @(negedge clk);
    vec++; if ({ifa.dac_cs, ifa.dac_sclk, ifa.busy, ifa.done, ifa.dac_sdo} !== 6'b0) begin
      err++; $display("FAIL mid_reset got cs=%b sclk=%b busy=%b done=%b sdo=%b want all 0",
                      ifa.dac_cs, ifa.dac_sclk, ifa.busy, ifa.done, ifa.dac_sdo);
    end
    rst_n = 1'b1;
    @(negedge clk);
    go(1'b0);
    mon(1'b0, 1, 200);
    check_two_frames("after_reset");
  endtask

  initial begin
    ifa.start = 1'b0; ifa.ch_mask = '0; ifa.cmd = '0; ifa.data = '0;
    ifb.start = 1'b0; ifb.ch_mask = '0; ifb.cmd = '0; ifb.data = '0;
    test_reset();
    test_two_ch();
    test_single();
    test_empty();
    test_wide();
    test_snapshot();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/dac_spi_multi.md
Name: dac_spi_multi

Overview:
- Parametrised successor of the two-channel 16-bit DAC serializer.
- Serialises one SPI frame per enabled DAC channel after a single start request. Each frame is command + data + zero pad, MSB first.
- Adds generalised channel count, word widths and SCLK divider, a per-channel enable mask, start/busy/done handshake, and CS setup/hold/gap timing.
- Sits between the delay/amplitude register file and the external DAC chips.

Parameters:
- CHANNELS, 2: number of DAC chip-selects (≥1).
- CMD_W, 4: command header bits per frame.
- DATA_W, 8: data bits per frame.
- FRAME_W, 16: total bits per frame. PAD = FRAME_W-CMD_W-DATA_W; elaboration error if PAD<0.
- CLK_DIV, 1: clk cycles per SCLK half-period (≥1).
- GAP_CLKS, 2: clk cycles with all CS inactive between frames (≥1).
- CS_ACT_LOW, 0: 1 means dac_cs is active-low; 0 means active-high.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  transfer request; sampled only in IDLE.
- ch_mask  in  CHANNELS  channel enable; bit i set means channel i gets a frame.
- cmd  in  CHANNELS*CMD_W  per-channel command header; channel i at [i*CMD_W +: CMD_W].
- data  in  CHANNELS*DATA_W  per-channel data; channel i at [i*DATA_W +: DATA_W].
- dac_sclk  out  1  SPI clock; idles low.
- dac_cs  out  CHANNELS  one-hot chip-select, polarity per CS_ACT_LOW.
- dac_sdo  out  1  serial data, MSB first.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the sequence completes.
- cur_ch  out  $clog2(CHANNELS) (min 1)  index of the channel being sent; 0 when idle.

Behaviour:
- Reset (rst_n=0 at a clk edge, including mid-frame):
  - state IDLE, dac_sclk=0, dac_cs all inactive, dac_sdo=0, busy=0, done=0, cur_ch=0, divider and bit counters cleared.
  - An aborted frame is not resumed.
- States: IDLE, LOAD, SETUP, SHIFT, HOLD, GAP, DONE.
- IDLE:
  - start=1 moves to LOAD next cycle.
  - start in any other state is ignored; start is not queued.
- LOAD (1 cycle):
  - Snapshot ch_mask, cmd and data. Later input changes do not affect the running sequence.
  - Select the lowest set mask bit.
  - If the mask is zero, go to DONE; no CS or SCLK activity occurs.
- SETUP (CLK_DIV cycles):
  - Assert dac_cs[cur_ch].
  - Shift register = {cmd_i, data_i, PAD zeros}; dac_sdo = bit FRAME_W-1.
- SHIFT (2*CLK_DIV*FRAME_W cycles):
  - SCLK toggles every CLK_DIV cycles, rising first.
  - On each falling edge, shift left with 0 fill; dac_sdo always shows the register MSB.
  - After the FRAME_W-th falling edge, go to HOLD.
- HOLD (CLK_DIV cycles):
  - dac_sclk=0 and CS still asserted, then CS deasserts.
- GAP (GAP_CLKS cycles):
  - All CS inactive, dac_sdo=0.
  - Then go to SETUP for the next higher set mask bit, or to DONE if none remain.
- DONE (1 cycle): done=1, busy=0 on the same cycle, then IDLE. A new start is accepted in the following IDLE cycle.
- Per-frame length: 2*CLK_DIV + 2*CLK_DIV*FRAME_W + GAP_CLKS clk cycles.
- At most one CS is asserted at any time. SCLK never toggles while CS is inactive.
- Disabled channels are skipped with zero cycles spent on them.

Decomposition:
- Package dac_spi_pkg:
  - state enum typedef.
  - Function frame_pad(FRAME_W, CMD_W, DATA_W).
  - Function next_ch(mask, cur): returns the next set bit above cur, or a "none" flag.
- Sub-module dac_sclk_div:
  - Counter over CLK_DIV, enabled in SHIFT.
  - Outputs sclk, rise_stb, fall_stb.
  - Cleared by rst_n and whenever not enabled.

Test Plan:
- Defaults, ch_mask=2'b11, cmd={4'b1111,4'b0111}, data={8'h3C,8'hA5}, start pulse -> ch0 frame 16'h7A50 sampled on SCLK rises under dac_cs=01, then ch1 frame 16'hF3C0 under dac_cs=10. done pulses 1+2*36+1 cycles after the start cycle.
- ch_mask=2'b10 -> only dac_cs[1] asserts, cur_ch=1, one frame 16'hF3C0. done 38 cycles after start.
- ch_mask=0 -> no CS or SCLK activity; busy high for 1 cycle; done pulse 2 cycles after start.
- CLK_DIV=3, CHANNELS=4, DATA_W=12, CMD_W=4, mask=4'b0101 -> SCLK half-period of 3 clks, frames on ch0 then ch2. Each frame has 16 rising edges with correct bits.
- start re-asserted mid-SHIFT, and data changed mid-sequence -> start ignored, transmitted bits match the LOAD snapshot, exactly one done pulse.
- rst_n low for one cycle at bit 7 of ch0 -> next cycle all CS inactive, SCLK=0, busy=0. A new start produces a complete, correct frame.
